// File: rtl/uart_pkg.sv
// Shared types and constants for the 8N1 UART transceiver.
package uart_pkg;

  localparam int FRAME_DATA_BITS = 8;
  localparam int RX_FIFO_DEPTH   = 4;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_START = 3'd1,
    TX_DATA  = 3'd2,
    TX_STOP  = 3'd3
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer: single holding register for DEPTH == 1, otherwise a ring FIFO.
// A push into a full buffer is dropped unless a pop happens in the same cycle.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = RX_FIFO_DEPTH,
  parameter int WIDTH = FRAME_DATA_BITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  if (DEPTH == 1) begin : g_hold
    logic [WIDTH-1:0] hold;
    logic             occupied;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && occupied;
    assign do_push = push && (!occupied || do_pop);
    assign data    = hold;
    assign valid   = occupied;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hold     <= '0;
        occupied <= 1'b0;
      end else begin
        if (do_push) hold <= push_data;
        if (do_push)     occupied <= 1'b1;
        else if (do_pop) occupied <= 1'b0;
      end
    end
  end else begin : g_ring
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full    = (count == FULL_CNT);
    assign valid   = (count != '0);
    assign do_pop  = pop && valid;
    // When full, a simultaneous pop frees the slot wr_ptr points at.
    assign do_push = push && (!full || do_pop);
    assign data    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_data;
          wr_ptr      <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
        end
        if (do_pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex 8N1 UART with ready/valid byte ports. Define UART_RX_FIFO_EN
// to replace the single receive holding register with a 4-entry FIFO.
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] DataIn,
  input  logic       DataInValid,
  output logic       DataInReady,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  input  logic       SerialIn,
  output logic       SerialOut
);

  localparam int CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(CLOCKS_PER_BIT);
  localparam int IW = $clog2(FRAME_DATA_BITS);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLOCKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(FRAME_DATA_BITS - 1);

`ifdef UART_RX_FIFO_EN
  localparam int RX_DEPTH = RX_FIFO_DEPTH;
`else
  localparam int RX_DEPTH = 1;
`endif

  // ---------------- transmitter ----------------
  tx_state_t                  tx_state, tx_next;
  logic [CW-1:0]              tx_cnt, tx_cnt_next;
  logic [IW-1:0]              tx_idx, tx_idx_next;
  logic [FRAME_DATA_BITS-1:0] tx_shift, tx_shift_next;
  logic                       tx_bit_done;
  logic                       tx_line;
  logic                       tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= tx_cnt_next;
      tx_idx   <= tx_idx_next;
      tx_shift <= tx_shift_next;
    end
  end

  always_comb begin
    tx_next       = tx_state;
    tx_cnt_next   = tx_cnt;
    tx_idx_next   = tx_idx;
    tx_shift_next = tx_shift;
    tx_line       = 1'b1;
    tx_ready      = 1'b0;
    tx_bit_done   = (tx_cnt == BIT_LAST);
    if (tx_state != TX_IDLE) tx_cnt_next = tx_bit_done ? '0 : tx_cnt + 1'b1;
    case (tx_state)
      TX_IDLE: begin
        tx_ready = 1'b1;
        if (DataInValid) begin
          tx_shift_next = DataIn;
          tx_cnt_next   = '0;
          tx_idx_next   = '0;
          tx_next       = TX_START;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_done) tx_next = TX_DATA;
      end
      TX_DATA: begin
        tx_line = tx_shift[0];
        if (tx_bit_done) begin
          tx_shift_next = tx_shift >> 1;
          tx_idx_next   = tx_idx + 1'b1;
          if (tx_idx == IDX_LAST) tx_next = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_done) tx_next = TX_IDLE;
      end
      default: tx_next = TX_IDLE;
    endcase
  end

  assign SerialOut   = tx_line;
  assign DataInReady = tx_ready;

  // ---------------- receiver ----------------
  rx_state_t                  rx_state, rx_next;
  logic [CW-1:0]              rx_cnt, rx_cnt_next;
  logic [IW-1:0]              rx_idx, rx_idx_next;
  logic [FRAME_DATA_BITS-1:0] rx_shift, rx_shift_next;
  logic                       rx_meta, rx_sync, rx_prev;
  logic                       rx_fall;
  logic                       rx_push;

  // Synchroniser and edge-detect flops reset to the idle level so that
  // leaving reset never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= SerialIn;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // A fall needs a preceding 1, so after a framing error the line must
  // return high before the next frame can start.
  assign rx_fall = rx_prev && !rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_state <= rx_next;
      rx_cnt   <= rx_cnt_next;
      rx_idx   <= rx_idx_next;
      rx_shift <= rx_shift_next;
    end
  end

  always_comb begin
    rx_next       = rx_state;
    rx_cnt_next   = rx_cnt;
    rx_idx_next   = rx_idx;
    rx_shift_next = rx_shift;
    rx_push       = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_next = '0;
          rx_idx_next = '0;
          rx_next     = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_next = '0;
          rx_next     = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync, rx_shift[FRAME_DATA_BITS-1:1]};
          rx_idx_next   = rx_idx + 1'b1;
          if (rx_idx == IDX_LAST) rx_next = RX_STOP;
        end else begin
          rx_cnt_next = rx_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_next = '0;
          rx_push     = rx_sync;
          rx_next     = RX_IDLE;
        end else begin
          rx_cnt_next = rx_cnt + 1'b1;
        end
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (FRAME_DATA_BITS)
  ) u_rx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (DataOutReady),
    .data      (DataOut),
    .valid     (DataOutValid)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
// Randomised self-checking bench for uart_transceiver at 16 clocks per bit,
// with a queue-based model of the receive buffer.
module tb_uart_transceiver;

  localparam int CPB = 16;
`ifdef UART_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] DataIn = 8'h00;
  logic       DataInValid = 1'b0;
  logic       DataInReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady = 1'b0;
  logic       SerialIn;
  logic       SerialOut;
  logic       rx_drive = 1'b1;
  logic       loop_en = 1'b0;

  int errors = 0;
  int checks = 0;
  logic [7:0] mq[$];

  assign SerialIn = loop_en ? SerialOut : rx_drive;

  always #5 clk = ~clk;

  uart_transceiver #(
    .CLOCK_FREQ (1600),
    .BAUD_RATE  (100)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .DataIn       (DataIn),
    .DataInValid  (DataInValid),
    .DataInReady  (DataInReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .SerialIn     (SerialIn),
    .SerialOut    (SerialOut)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Caller sits at a negedge; returns at the negedge where DataInReady is back.
  task automatic tx_frame(input logic [7:0] b);
    logic [9:0] bits;
    int w;
    bits = {1'b1, b, 1'b0};
    w = 0;
    while (!DataInReady && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("tx_ready_wait", DataInReady, 1);
    DataIn = b;
    DataInValid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10 * CPB; i++) begin
      check("tx_line", SerialOut, bits[i / CPB]);
      check("tx_busy", DataInReady, 0);
      DataIn = 8'($urandom);
      DataInValid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    DataInValid = 1'b0;
    check("tx_ready_after", DataInReady, 1);
  endtask

  // Drives one frame on rx_drive; lat = first cycle index DataOutValid seen.
  task automatic drive_rx(input logic [7:0] b, input logic stop_bit, input int pop_at,
                          output int lat, output logic [7:0] popped);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    lat = -1;
    popped = 8'h00;
    for (int k = 0; k < 10 * CPB; k++) begin
      if (lat < 0 && DataOutValid) lat = k;
      if (k == pop_at) begin
        popped = DataOut;
        DataOutReady = 1'b1;
      end else begin
        DataOutReady = 1'b0;
      end
      rx_drive = bits[k / CPB];
      @(negedge clk);
    end
    DataOutReady = 1'b0;
    rx_drive = 1'b1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic stop_bit);
    int lat;
    logic [7:0] p;
    drive_rx(b, stop_bit, -1, lat, p);
    if (stop_bit && mq.size() < DEPTH) mq.push_back(b);
  endtask

  task automatic idle(input int n);
    rx_drive = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_one(input logic [7:0] exp);
    int w;
    w = 0;
    while (!DataOutValid && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("pop_valid", DataOutValid, 1);
    check("pop_data", DataOut, exp);
    DataOutReady = 1'b1;
    @(negedge clk);
    DataOutReady = 1'b0;
  endtask

  task automatic pop_model();
    while (mq.size() > 0) pop_one(mq.pop_front());
    check("drained", DataOutValid, 0);
  endtask

  initial begin
    #800_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [7:0] p, b;
    int n;

    repeat (3) @(negedge clk);
    check("rst_serial_out", SerialOut, 1);
    check("rst_in_ready", DataInReady, 1);
    check("rst_out_valid", DataOutValid, 0);
    check("rst_data_out", DataOut, 8'h00);
    rst_n = 1'b1;
    idle(5);

    tx_frame(8'hA5);
    idle(3);

    drive_rx(8'h3C, 1'b1, -1, lat, p);
    check("rx_latency", lat, 155);
    check("rx_data", DataOut, 8'h3C);
    check("rx_valid", DataOutValid, 1);
    DataOutReady = 1'b1;
    @(negedge clk);
    DataOutReady = 1'b0;
    check("pop_clears_valid", DataOutValid, 0);
    idle(10);

    rx_drive = 1'b0;
    repeat (4) @(negedge clk);
    idle(60);
    check("glitch_no_byte", DataOutValid, 0);
    rx_byte(8'h96, 1'b1);
    idle(5);
    pop_model();

    drive_rx(8'h77, 1'b0, -1, lat, p);
    idle(30);
    check("framing_no_byte", DataOutValid, 0);
    rx_byte(8'h42, 1'b1);
    idle(3);
    pop_model();

    rx_byte(8'h11, 1'b1);
    idle(4);
    rx_byte(8'h22, 1'b1);
    idle(4);
    check("hold_oldest", DataOut, 8'h11);
    rx_byte(8'h33, 1'b1);
    idle(4);
    rx_byte(8'h44, 1'b1);
    idle(4);
    rx_byte(8'h55, 1'b1);
    idle(4);
    check("full_valid", DataOutValid, 1);
    pop_model();

    // Full buffer: pop lands in the same cycle as the next push.
    for (int i = 0; i < DEPTH; i++) begin
      rx_byte(8'($urandom), 1'b1);
      idle(3);
    end
    b = 8'($urandom);
    drive_rx(b, 1'b1, 154, lat, p);
    check("simul_pop_data", p, mq.pop_front());
    mq.push_back(b);
    check("simul_valid", DataOutValid, 1);
    check("simul_head", DataOut, mq[0]);
    pop_model();

    for (int r = 0; r < 4; r++) begin
      fork
        begin
          for (int t = 0; t < 2; t++) tx_frame(8'($urandom));
        end
        begin
          n = $urandom_range(1, DEPTH + 2);
          for (int j = 0; j < n; j++) begin
            rx_byte(8'($urandom), 1'($urandom_range(0, 4) != 0));
            idle($urandom_range(1, 30));
          end
        end
      join
      check("rand_valid", DataOutValid, mq.size() != 0);
      pop_model();
    end

    loop_en = 1'b1;
    idle(5);
    fork
      begin
        tx_frame(8'h00);
        tx_frame(8'hFF);
        tx_frame(8'h5A);
      end
      begin
        pop_one(8'h00);
        pop_one(8'hFF);
        pop_one(8'h5A);
      end
    join
    idle(20);
    check("loop_drained", DataOutValid, 0);
    loop_en = 1'b0;
    idle(5);

    rx_byte(8'hC3, 1'b1);
    idle(3);
    DataIn = 8'h00;
    DataInValid = 1'b1;
    rx_drive = 1'b0;
    @(negedge clk);
    DataInValid = 1'b0;
    repeat (80) @(negedge clk);
    check("mid_tx_low", SerialOut, 0);
    check("mid_rx_held", DataOutValid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_serial_out", SerialOut, 1);
    check("arst_in_ready", DataInReady, 1);
    check("arst_out_valid", DataOutValid, 0);
    check("arst_data_out", DataOut, 8'h00);
    mq.delete();
    @(negedge clk);
    rx_drive = 1'b1;
    rst_n = 1'b1;
    idle(10);
    tx_frame(8'h3E);
    rx_byte(8'hE3, 1'b1);
    idle(3);
    pop_model();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_transceiver.md
# uart_transceiver

Full-duplex 8N1 UART sitting directly downstream of the memory-mapped UART decoder in the MIPS processor. It accepts bytes to transmit over a ready/valid input port and serialises them onto the TX pin. It deserialises bytes from the RX pin and presents them over a ready/valid output port. The decoder's `Write`/`DataInValid` drive the input port; its `Read`, `DataInReady` and `DataOutValid` inputs come from this block.

## Interface
- `CLOCK_FREQ`, default 50_000_000: system clock in Hz.
- `BAUD_RATE`, default 115_200: line rate in bits per second.
- Derived constant `CLOCKS_PER_BIT = CLOCK_FREQ / BAUD_RATE` (integer divide). It must be ≥ 4.
- `clk` in 1: system clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `DataIn` in 8: byte to transmit.
- `DataInValid` in 1: `DataIn` is valid.
- `DataInReady` out 1: the transmitter can accept a byte.
- `DataOut` out 8: received byte.
- `DataOutValid` out 1: `DataOut` holds an unread byte.
- `DataOutReady` in 1: the consumer takes `DataOut` this cycle.
- `SerialIn` in 1: RX line, asynchronous to `clk`, idle high.
- `SerialOut` out 1: TX line, idle high.

## Operation
- Reset values:
  - `SerialOut` = 1.
  - `DataInReady` = 1.
  - `DataOutValid` = 0.
  - `DataOut` = 8'h00.
  - Both FSMs return to IDLE.
  - All counters are 0.
- Reset asserted mid-frame aborts the frame immediately. `SerialOut` returns to 1 asynchronously.
- TX FSM states: IDLE → START → DATA → STOP → IDLE.
  - `DataInReady` = 1 only in IDLE.
  - A handshake occurs when `DataInValid && DataInReady`. It latches `DataIn` into the shift register and moves the FSM to START.
  - START drives 0. DATA drives bits 0..7, LSB first. STOP drives 1.
  - Each state or bit lasts exactly `CLOCKS_PER_BIT` cycles.
  - `DataIn` is ignored outside the handshake cycle.
- RX path: `SerialIn` passes through a 2-flop synchroniser. All RX logic uses the synchronised value.
- RX FSM states: IDLE → START → DATA → STOP → IDLE.
  - IDLE: a synchronised 1→0 transition moves to START and loads the bit counter.
  - START: sample at `CLOCKS_PER_BIT/2`. If the sample is 1 (false start), return to IDLE. If 0, go to DATA.
  - DATA: sample 8 bits, each `CLOCKS_PER_BIT` after the previous sample, and shift in LSB first.
  - STOP: sample one bit period later.
    - Stop = 1: push the byte into the receive buffer.
    - Stop = 0 (framing error): discard the byte.
    - In either case return to IDLE, then wait for the line to read 1 before re-arming edge detection.
- Receive buffer (default: single holding register):
  - `DataOutValid` = buffer non-empty. `DataOut` = oldest byte.
  - A pop occurs on `DataOutValid && DataOutReady`.
  - Push while full, no pop in the same cycle: the new byte is dropped and the held byte is unchanged (overrun).
  - Push and pop in the same cycle while full: the pop is performed and the new byte is stored. Nothing is dropped.
  - `DataOutReady` while empty has no effect.
- TX and RX are fully independent. They may run simultaneously, and loopback (`SerialOut` tied to `SerialIn`) must work.

## Timing
- TX latency: handshake in cycle N → `SerialOut` = 0 from cycle N+1.
- TX frame length: 10·`CLOCKS_PER_BIT` cycles.
- `DataInReady` rises in the cycle after the last STOP cycle. A back-to-back frame may be accepted in that cycle.
- RX latency: `DataOutValid` rises in the cycle after the stop-bit sample. That is ≈ 9.5·`CLOCKS_PER_BIT` + 3 cycles after the line falls (2 cycles of synchroniser, 1 cycle of edge detect).
- RX sampling point: centre of bit ± 1 clock.
- `DataOut` is stable while `DataOutValid` = 1 and no pop occurs.
- Bit counters wrap at `CLOCKS_PER_BIT-1` → 0. Their width is `$clog2(CLOCKS_PER_BIT)`.

## Configuration
- `UART_RX_FIFO_EN` defined: the holding register is replaced by a 4-entry receive FIFO.
  - `DataOutValid` = FIFO non-empty.
  - Overrun occurs only when 4 bytes are held.
  - Pointers are 2 bits, wrap modulo 4, plus a full/empty count of 3 bits.
  - Push and pop in the same cycle at any occupancy keep the count unchanged and lose nothing.
- `UART_RX_FIFO_EN` undefined: single holding register, behaving as described under Operation.

## Structure
- Shared package `uart_pkg`:
  - TX and RX state encodings (3-bit localparams IDLE/START/DATA/STOP).
  - `FRAME_DATA_BITS` = 8.
  - `RX_FIFO_DEPTH` = 4.
- Sub-module `uart_rx_fifo`: receive buffer with depth parameter. It is instantiated with depth 1 when `UART_RX_FIFO_EN` is undefined.
- The TX and RX FSMs stay in the top module.

## Test plan
All scenarios use `CLOCK_FREQ` = 1600 and `BAUD_RATE` = 100, giving `CLOCKS_PER_BIT` = 16.
- TX 8'hA5 → `SerialOut` carries 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. `DataInReady` is low for exactly 160 cycles.
- Drive an RX frame of 8'h3C → `DataOutValid` rises ≈155 cycles after the falling edge with `DataOut` = 8'h3C. Pulse `DataOutReady` → `DataOutValid` = 0 on the next cycle.
- Glitch on RX (low for 4 cycles) → no byte received and the FSM returns to IDLE. Frame with stop bit = 0 → `DataOutValid` stays 0.
- Without `DataOutReady`, receive 8'h11 then 8'h22 → default build holds 8'h11. The FIFO build holds 8'h11 and 8'h22 and pops them in order. Sending a 5th byte to a full FIFO drops that byte.
- Loopback with back-to-back TX 8'h00, 8'hFF, 8'h5A → the same three bytes are received in order. Frames are separated by no idle gaps.
- Assert `rst_n` mid-TX and mid-RX → `SerialOut` = 1 and `DataOutValid` = 0 immediately. The next full frame after release transfers correctly.
